// File: rtl/irq_ctrl_if.sv
// irq_ctrl_if: request/response bundle between the interrupt controller
// and its surroundings (peripheral IRQ lines, enables, pipeline boundary
// handshake, PC trap/return signals).
//   slave  : the controller side (consumes requests, drives cause/ack/status)
//   master : the peripheral/pipeline side (drives requests, observes status)
interface irq_ctrl_if;
    logic [2:0] irq_i;        // raw interrupt lines, src k = bit k
    logic [2:0] irq_en_i;     // per-source enable mask
    logic       gie_i;        // global interrupt enable
    logic       take_ok_i;    // pipeline at a clean instruction boundary
    logic       mret_i;       // qualified mret from decode
    logic [1:0] int_cause_o;  // 0 = none, src k -> k+1, one-cycle pulse
    logic [2:0] irq_ack_o;    // one-hot ack, pulses with int_cause_o
    logic       in_service_o; // high while a handler runs
    logic [1:0] active_src_o; // source in service (valid with in_service_o)
    logic [2:0] pending_o;    // pending vector before masking

    modport slave (
        input  irq_i, irq_en_i, gie_i, take_ok_i, mret_i,
        output int_cause_o, irq_ack_o, in_service_o, active_src_o, pending_o
    );

    modport master (
        output irq_i, irq_en_i, gie_i, take_ok_i, mret_i,
        input  int_cause_o, irq_ack_o, in_service_o, active_src_o, pending_o
    );
endinterface

// File: rtl/irq_ctrl.sv
// irq_ctrl: three-source interrupt controller sequencing the PC trap and
// return path. Synchronizes the raw lines, tracks pending state (edge or
// level per source), arbitrates (fixed or round-robin) and issues a
// one-cycle cause/ack pulse at a clean instruction boundary. Further
// interrupts are blocked until mret, followed by one RETURN cycle so at
// least one instruction of the interrupted program executes.
// Ports:
//   clk  - clock
//   rst  - asynchronous, active-high reset
//   bus  - irq_ctrl_if.slave (see interface for signal meanings)
module irq_ctrl #(
    parameter logic [2:0] EDGE_MASK   = 3'b000, // 1 = rising-edge latched, 0 = level
    parameter bit         RR          = 1'b0,   // 0 = fixed priority, 1 = round-robin
    parameter int         SYNC_STAGES = 2       // 0..3, 0 = bypass
) (
    input  logic        clk,
    input  logic        rst,
    irq_ctrl_if.slave   bus
);

    typedef enum logic [1:0] {IDLE, SERVICE, RETURN} state_t;

    state_t     state;
    logic [2:0] irq_s;
    logic [2:0] irq_hist;
    logic [2:0] edge_pend;
    logic [2:0] elig;
    logic [1:0] rr_ptr;
    logic [1:0] grant_idx;
    logic [1:0] cand;
    logic       grant_vld;
    logic       take;

    // Input synchronizer
    generate
        if (SYNC_STAGES == 0) begin : g_nosync
            assign irq_s = bus.irq_i;
        end else begin : g_sync
            logic [SYNC_STAGES-1:0][2:0] sync_q;
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    sync_q <= '0;
                end else begin
                    sync_q[0] <= bus.irq_i;
                    for (int i = 1; i < SYNC_STAGES; i++)
                        sync_q[i] <= sync_q[i-1];
                end
            end
            assign irq_s = sync_q[SYNC_STAGES-1];
        end
    endgenerate

    // Edge pending: the clear uses the registered ack, so it lands at the
    // end of the ack cycle; a rising edge seen at that same edge wins.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            irq_hist  <= '0;
            edge_pend <= '0;
        end else begin
            irq_hist  <= irq_s;
            edge_pend <= ((edge_pend & ~bus.irq_ack_o) | (irq_s & ~irq_hist)) & EDGE_MASK;
        end
    end

    // Level sources follow the synchronized line directly.
    assign bus.pending_o = edge_pend | (irq_s & ~EDGE_MASK);
    assign elig          = bus.pending_o & bus.irq_en_i;

    // Arbitration. Loops run from lowest to highest priority so the last
    // hit (highest priority) overwrites earlier ones.
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = '0;
        cand      = '0;
        if (!RR) begin
            for (int k = 2; k >= 0; k--) begin
                if (elig[k]) begin
                    grant_vld = 1'b1;
                    grant_idx = 2'(k);
                end
            end
        end else begin
            for (int off = 3; off >= 1; off--) begin
                cand = 2'((int'(rr_ptr) + off) % 3);
                if (elig[cand]) begin
                    grant_vld = 1'b1;
                    grant_idx = cand;
                end
            end
        end
    end

    assign take = (state == IDLE) && bus.gie_i && bus.take_ok_i && grant_vld;

    // Control FSM with registered outputs. The first SERVICE cycle is the
    // one carrying a nonzero cause; mret is ignored there.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state            <= IDLE;
            bus.int_cause_o  <= '0;
            bus.irq_ack_o    <= '0;
            bus.in_service_o <= 1'b0;
            bus.active_src_o <= '0;
            rr_ptr           <= 2'd2;
        end else begin
            bus.int_cause_o <= '0;
            bus.irq_ack_o   <= '0;
            case (state)
                IDLE: begin
                    if (take) begin
                        state            <= SERVICE;
                        bus.int_cause_o  <= grant_idx + 2'd1;
                        bus.irq_ack_o    <= 3'b001 << grant_idx;
                        bus.in_service_o <= 1'b1;
                        bus.active_src_o <= grant_idx;
                        rr_ptr           <= grant_idx;
                    end
                end
                SERVICE: begin
                    if (bus.int_cause_o == '0 && bus.mret_i) begin
                        state            <= RETURN;
                        bus.in_service_o <= 1'b0;
                    end
                end
                RETURN:  state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_irq_ctrl.sv
// tb_irq_ctrl: directed bench for irq_ctrl. Three instances cover the
// parameter space: dut_e (edge on src0/src2, fixed, no sync), dut_f
// (level, fixed, no sync), dut_r (level, round-robin, 2-stage sync).
module tb_irq_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;
    int   cause_seq [4] = '{1, 2, 3, 1};

    always #5 clk = ~clk;

    irq_ctrl_if bus_e ();
    irq_ctrl_if bus_f ();
    irq_ctrl_if bus_r ();

    irq_ctrl #(.EDGE_MASK(3'b101), .RR(1'b0), .SYNC_STAGES(0)) dut_e (
        .clk(clk), .rst(rst), .bus(bus_e.slave));
    irq_ctrl #(.EDGE_MASK(3'b000), .RR(1'b0), .SYNC_STAGES(0)) dut_f (
        .clk(clk), .rst(rst), .bus(bus_f.slave));
    irq_ctrl #(.EDGE_MASK(3'b000), .RR(1'b1), .SYNC_STAGES(2)) dut_r (
        .clk(clk), .rst(rst), .bus(bus_r.slave));

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0d want %0d", tag, obs, exp);
        end
    endtask

    initial begin
        bus_e.irq_i = '0; bus_e.irq_en_i = 3'b111; bus_e.gie_i = 1'b1;
        bus_e.take_ok_i = 1'b1; bus_e.mret_i = 1'b0;
        bus_f.irq_i = '0; bus_f.irq_en_i = 3'b111; bus_f.gie_i = 1'b1;
        bus_f.take_ok_i = 1'b1; bus_f.mret_i = 1'b0;
        bus_r.irq_i = '0; bus_r.irq_en_i = 3'b111; bus_r.gie_i = 1'b1;
        bus_r.take_ok_i = 1'b1; bus_r.mret_i = 1'b0;

        // Reset values
        tick; tick;
        chk("rst_cause",   int'(bus_e.int_cause_o),  0);
        chk("rst_ack",     int'(bus_e.irq_ack_o),    0);
        chk("rst_insvc",   int'(bus_e.in_service_o), 0);
        chk("rst_pending", int'(bus_e.pending_o),    0);
        rst = 1'b0;
        tick;

        // Single edge source: src0 pulse
        bus_e.irq_i = 3'b001;
        tick;
        chk("edge_pend", int'(bus_e.pending_o),   1);
        chk("edge_nocause", int'(bus_e.int_cause_o), 0);
        bus_e.irq_i = 3'b000;
        tick;
        chk("edge_cause", int'(bus_e.int_cause_o),  1);
        chk("edge_ack",   int'(bus_e.irq_ack_o),    1);
        chk("edge_insvc", int'(bus_e.in_service_o), 1);
        tick;
        chk("edge_cause_pulse", int'(bus_e.int_cause_o), 0);
        chk("edge_ack_pulse",   int'(bus_e.irq_ack_o),   0);
        chk("edge_hold",        int'(bus_e.in_service_o), 1);
        chk("edge_cleared",     int'(bus_e.pending_o),    0);
        tick;
        bus_e.mret_i = 1'b1;
        tick;
        chk("edge_return", int'(bus_e.in_service_o), 0);
        bus_e.mret_i = 1'b0;
        tick;
        chk("edge_idle", int'(bus_e.int_cause_o), 0);

        // Simultaneous: new edge and mret during the ack cycle
        bus_e.irq_i = 3'b001;
        tick;
        bus_e.irq_i = 3'b000;
        tick;
        chk("sim_cause", int'(bus_e.int_cause_o), 1);
        bus_e.irq_i = 3'b001;
        bus_e.mret_i = 1'b1;
        tick;
        chk("sim_pend_kept", int'(bus_e.pending_o[0]), 1);
        chk("sim_mret_ign",  int'(bus_e.in_service_o), 1);
        bus_e.irq_i = 3'b000;
        bus_e.mret_i = 1'b0;
        tick;
        bus_e.mret_i = 1'b1;
        tick;
        chk("sim_return", int'(bus_e.in_service_o), 0);
        bus_e.mret_i = 1'b0;
        tick;
        chk("sim_ret_gap", int'(bus_e.int_cause_o), 0);
        tick;
        chk("sim_regrant", int'(bus_e.int_cause_o), 1);
        tick;
        bus_e.mret_i = 1'b1;
        tick;
        bus_e.mret_i = 1'b0;
        tick;

        // Gating: gie low, then take_ok low
        bus_e.gie_i = 1'b0;
        bus_e.irq_i = 3'b100;
        tick;
        chk("gate_pend", int'(bus_e.pending_o), 4);
        bus_e.irq_i = 3'b000;
        tick;
        chk("gate_gie_cause", int'(bus_e.int_cause_o), 0);
        chk("gate_pend_hold", int'(bus_e.pending_o[2]), 1);
        tick;
        chk("gate_gie_insvc", int'(bus_e.in_service_o), 0);
        bus_e.gie_i = 1'b1;
        bus_e.take_ok_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick;
            chk("gate_takeok", int'(bus_e.int_cause_o), 0);
        end
        bus_e.take_ok_i = 1'b1;
        tick;
        chk("gate_cause",  int'(bus_e.int_cause_o),  3);
        chk("gate_ack",    int'(bus_e.irq_ack_o),    4);
        chk("gate_active", int'(bus_e.active_src_o), 2);
        bus_e.gie_i = 1'b0;
        bus_e.irq_en_i = 3'b000;
        tick;
        chk("gate_drop_cause", int'(bus_e.int_cause_o),  0);
        chk("gate_drop_insvc", int'(bus_e.in_service_o), 1);
        bus_e.mret_i = 1'b1;
        tick;
        chk("gate_return", int'(bus_e.in_service_o), 0);
        bus_e.mret_i = 1'b0;
        bus_e.gie_i = 1'b1;
        bus_e.irq_en_i = 3'b111;
        tick;

        // Fixed priority, level sources
        bus_f.irq_i = 3'b110;
        #1;
        chk("fix_pend", int'(bus_f.pending_o), 6);
        tick;
        chk("fix_cause1", int'(bus_f.int_cause_o), 2);
        chk("fix_ack1",   int'(bus_f.irq_ack_o),   2);
        tick;
        chk("fix_level_kept", int'(bus_f.pending_o), 6);
        bus_f.mret_i = 1'b1;
        tick;
        chk("fix_return", int'(bus_f.in_service_o), 0);
        bus_f.mret_i = 1'b0;
        tick;
        chk("fix_ret_gap", int'(bus_f.int_cause_o), 0);
        tick;
        chk("fix_cause2", int'(bus_f.int_cause_o), 2);

        // Round-robin with 2-stage synchronizer
        bus_r.irq_i = 3'b111;
        tick;
        chk("rr_sync1", int'(bus_r.pending_o), 0);
        tick;
        chk("rr_sync2", int'(bus_r.pending_o), 7);
        chk("rr_nocause", int'(bus_r.int_cause_o), 0);
        tick;
        chk("rr_cause0", int'(bus_r.int_cause_o), cause_seq[0]);
        for (int i = 1; i < 4; i++) begin
            tick;
            chk("rr_pulse", int'(bus_r.int_cause_o), 0);
            bus_r.mret_i = 1'b1;
            tick;
            bus_r.mret_i = 1'b0;
            tick;
            tick;
            chk("rr_cause", int'(bus_r.int_cause_o), cause_seq[i]);
        end

        // Reset mid-service
        bus_e.irq_i = 3'b100;
        tick;
        bus_e.irq_i = 3'b000;
        tick;
        chk("mid_cause", int'(bus_e.int_cause_o), 3);
        tick;
        rst = 1'b1;
        #1;
        chk("mid_rst_insvc",  int'(bus_e.in_service_o), 0);
        chk("mid_rst_active", int'(bus_e.active_src_o), 0);
        chk("mid_rst_pend",   int'(bus_e.pending_o),    0);
        chk("mid_rst_f",      int'(bus_f.in_service_o), 0);
        tick;
        rst = 1'b0;
        tick;
        chk("post_rst_insvc", int'(bus_e.in_service_o), 0);
        chk("post_rst_cause", int'(bus_e.int_cause_o),  0);
        bus_e.irq_i = 3'b100;
        tick;
        bus_e.irq_i = 3'b000;
        tick;
        chk("post_rst_grant", int'(bus_e.int_cause_o), 3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
